opram_arb: RTL and testbench

//   Shares the single-port 256x8 opcode RAM between two requesters: port 0 = core

---
 rtl/opram_arb_pkg.sv | 19 +
 rtl/opram_arb_rr.sv | 44 ++++
 rtl/opram_arb.sv | 140 ++++++++++++++
 tb/tb_opram_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opram_arb_pkg
// Brief    : Shared arbiter state encoding and port-index constants for opram_arb.
// Revision : 1.0 - initial release
// ============================================================================
package opram_arb_pkg;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic c_PORT0 = 1'b0;
    localparam logic c_PORT1 = 1'b1;

endpackage : opram_arb_pkg
`default_nettype wire

// File: rtl/opram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : opram_arb_rr
// Brief    : Two-way round-robin pick between eligible ports, owns rr_last.
// Revision : 1.0 - initial release
// ============================================================================
module opram_arb_rr
    import opram_arb_pkg::*;
#(
    parameter int P0_FIRST = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic elig0,
    input  logic elig1,
    output logic grant_valid,
    output logic grant_port
);

    // Index of the last accepted port; preset so the first contest goes to the
    // port selected by P0_FIRST.
    logic r_rr_last;

    always_comb begin
        grant_valid = elig0 | elig1;
        if (elig0 && elig1) begin
            grant_port = ~r_rr_last;
        end else if (elig1) begin
            grant_port = c_PORT1;
        end else begin
            grant_port = c_PORT0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last <= (P0_FIRST != 0) ? c_PORT1 : c_PORT0;
        end else if (grant_valid) begin
            r_rr_last <= grant_port;
        end
    end

endmodule : opram_arb_rr
`default_nettype wire

// File: rtl/opram_arb.sv
`default_nettype none
// ============================================================================
// Module   : opram_arb
// Brief    : Arbitrates the single-port opcode RAM between core fetch (port 0)
//            and host loader/debug (port 1) with round-robin and burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module opram_arb
    import opram_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int P0_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t        r_state;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [ADDR_W-1:0] r_ad_hold;
    logic [DATA_W-1:0] r_din_hold;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant_valid;
    logic              w_grant_port;
    logic              w_ack0;
    logic              w_ack1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_ad;
    logic [DATA_W-1:0] w_sel_din;

    // An owner holding its request blocks the other port; an idle owner does not.
    assign w_elig0 = ~reset & req0 & ~((r_state == ST_OWN1) & req1);
    assign w_elig1 = ~reset & req1 & ~((r_state == ST_OWN0) & req0);

    opram_arb_rr #(
        .P0_FIRST (P0_FIRST)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .elig0       (w_elig0),
        .elig1       (w_elig1),
        .grant_valid (w_grant_valid),
        .grant_port  (w_grant_port)
    );

    assign w_ack0 = w_grant_valid & (w_grant_port == c_PORT0);
    assign w_ack1 = w_grant_valid & (w_grant_port == c_PORT1);

    assign w_sel_we  = w_ack1 ? we1    : we0;
    assign w_sel_ad  = w_ack1 ? addr1  : addr0;
    assign w_sel_din = w_ack1 ? wdata1 : wdata0;

    assign ack0      = w_ack0;
    assign ack1      = w_ack1;
    assign ram_ce    = w_grant_valid;
    assign ram_wre   = w_grant_valid & w_sel_we;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;
    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    assign ram_ad    = w_grant_valid ? w_sel_ad  : r_ad_hold;
    assign ram_din   = w_grant_valid ? w_sel_din : r_din_hold;

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_ad_hold  <= '0;
            r_din_hold <= '0;
        end else begin
            r_rvalid0 <= w_ack0 & ~we0;
            r_rvalid1 <= w_ack1 & ~we1;
            if (w_grant_valid) begin
                r_ad_hold  <= w_sel_ad;
                r_din_hold <= w_sel_din;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FREE;
        end else begin
            case (r_state)
                ST_FREE: begin
                    if (w_ack0 && lock0) begin
                        r_state <= ST_OWN0;
                    end else if (w_ack1 && lock1) begin
                        r_state <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    // Releasing owner may coincide with the other port taking a lock.
                    if (!lock0 && (w_ack0 || !req0)) begin
                        r_state <= (w_ack1 && lock1) ? ST_OWN1 : ST_FREE;
                    end
                end
                ST_OWN1: begin
                    if (!lock1 && (w_ack1 || !req1)) begin
                        r_state <= (w_ack0 && lock0) ? ST_OWN0 : ST_FREE;
                    end
                end
                default: r_state <= ST_FREE;
            endcase
        end
    end

endmodule : opram_arb
`default_nettype wire

// File: tb/tb_opram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_opram_arb
// Brief    : Self-checking bench for opram_arb with a behavioural 256x8 RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opram_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic       lock0 = 1'b0, lock1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_ce, ram_oce, ram_wre, ram_reset;
    logic [7:0] ram_ad, ram_din;
    logic [7:0] ram_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    opram_arb #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .P0_FIRST (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_wre   (ram_wre),
        .ram_reset (ram_reset),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural sync-read RAM, preloaded with addr ^ 0x47.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i) ^ 8'h47;
            shadow[i] = 8'(i) ^ 8'h47;
        end
    end

    always @(posedge clk) begin
        if (ram_reset) begin
            ram_dout <= 8'h00;
        end else if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout <= mem[ram_ad];
        end
    end

    // Scoreboard: expected read data queued on accepted reads, checked on rvalid.
    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (rvalid0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb_rvalid0_unexpected rdata0=%02h none expected", rdata0);
                end else begin
                    logic [7:0] exp0;
                    exp0 = q0.pop_front();
                    if (rdata0 !== exp0) begin
                        errors++;
                        $display("FAIL sb_rdata0 got=%02h exp=%02h", rdata0, exp0);
                    end
                end
            end
            if (rvalid1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb_rvalid1_unexpected rdata1=%02h none expected", rdata1);
                end else begin
                    logic [7:0] exp1;
                    exp1 = q1.pop_front();
                    if (rdata1 !== exp1) begin
                        errors++;
                        $display("FAIL sb_rdata1 got=%02h exp=%02h", rdata1, exp1);
                    end
                end
            end
            if (ack0 || ack1) begin
                checks++;
                if (ack0 && ack1) begin
                    errors++;
                    $display("FAIL sb_dual_ack ack0=%b ack1=%b exp one-hot", ack0, ack1);
                end
            end
            if (ack0) begin
                if (we0) shadow[addr0] = wdata0;
                else     q0.push_back(shadow[addr0]);
            end
            if (ack1) begin
                if (we1) shadow[addr1] = wdata1;
                else     q1.push_back(shadow[addr1]);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if ({ram_ce, ack0, ack1, rvalid0, rvalid1} !== 5'b0) begin
                errors++;
                $display("FAIL %s_idle cyc=%0d {ce,ack0,ack1,rv0,rv1}=%b exp=00000",
                         tag, c, {ram_ce, ack0, ack1, rvalid0, rvalid1});
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_idle("reset", 10);
    endtask

    task automatic test_single_read();
        @(posedge clk); #1 req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || ram_ad !== 8'h00) begin
            errors++;
            $display("FAIL single_ack ack0=%b ack1=%b ad=%02h exp 1 0 00", ack0, ack1, ram_ad);
        end
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h47) begin
            errors++;
            $display("FAIL single_rdata rvalid0=%b rdata0=%02h exp 1 47", rvalid0, rdata0);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        @(posedge clk); #1
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp;
            exp = (k % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({ack0, ack1} !== exp) begin
                errors++;
                $display("FAIL alt_ack cyc=%0d {ack0,ack1}=%b exp=%b", k, {ack0, ack1}, exp);
            end
        end
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock();
        @(posedge clk); #1
        req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 8'h10; wdata1 = 8'hA0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk); #1
                addr1  = 8'(16 + i);
                wdata1 = 8'(8'hA0 + i);
                lock1  = (i != 3);
                if (i == 1) begin
                    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h12;
                end
            end
            @(negedge clk);
            checks++;
            if (ack1 !== 1'b1 || ack0 !== 1'b0 || ram_wre !== 1'b1) begin
                errors++;
                $display("FAIL lock_beat%0d ack0=%b ack1=%b wre=%b exp 0 1 1",
                         i, ack0, ack1, ram_wre);
            end
        end
        @(posedge clk); #1 req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL lock_release ack0=%b ack1=%b exp 1 0", ack0, ack1);
        end
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'hA2) begin
            errors++;
            $display("FAIL lock_read rvalid0=%b rdata0=%02h exp 1 A2", rvalid0, rdata0);
        end
    endtask

    task automatic test_raw();
        @(posedge clk); #1 req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h5A;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || ram_wre !== 1'b1) begin
            errors++;
            $display("FAIL raw_wr_ack ack0=%b wre=%b exp 1 1", ack0, ram_wre);
        end
        @(posedge clk); #1 we0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b0 || ack0 !== 1'b1) begin
            errors++;
            $display("FAIL raw_wr_no_rvalid rvalid0=%b ack0=%b exp 0 1", rvalid0, ack0);
        end
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A) begin
            errors++;
            $display("FAIL raw_rdata rvalid0=%b rdata0=%02h exp 1 5A", rvalid0, rdata0);
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1 req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ack ack0=%b exp 1", ack0);
        end
        #2 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid0 !== 1'b0 || ack0 !== 1'b0 || ram_ce !== 1'b0) begin
            errors++;
            $display("FAIL midrst_drop rvalid0=%b ack0=%b ce=%b exp 0 0 0",
                     rvalid0, ack0, ram_ce);
        end
        @(posedge clk); #1 req0 = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        check_idle("midrst", 10);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_raw();
        test_reset_mid_read();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_opram_arb
`default_nettype wire
